mmcm_drp_reconfig_ctrl: RTL and testbench

//  Sequences dynamic reconfiguration of one MMCME2_ADV through its DRP port.

---
 rtl/mmcm_drp_reconfig_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mmcm_drp_reconfig_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_reconfig_ctrl.sv
// MMCM dynamic reconfiguration sequencer.
// Applies a loadable table of masked DRP read-modify-write operations while the
// MMCM is held in reset, then releases reset and waits for LOCKED.
// Every wait (DRDY, LOCKED) is bounded; an expiry aborts with a sticky error.
module mmcm_drp_reconfig_ctrl #(
  parameter int DEPTH        = 32,
  parameter int IDX_W        = 5,
  parameter int RST_HOLD_CYC = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_idx,
  input  logic [38:0]      tbl_wdata,
  input  logic [IDX_W:0]   num_ent,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mmcm_rst,
  output logic             den,
  output logic             dwe,
  output logic [6:0]       daddr,
  output logic [15:0]      di,
  input  logic [15:0]      drp_do,
  input  logic             drdy,
  input  logic             locked
);

  localparam int CNT_MAX_A = (DRDY_TIMEOUT > RST_HOLD_CYC) ? DRDY_TIMEOUT : RST_HOLD_CYC;
  localparam int CNT_MAX   = (LOCK_TIMEOUT > CNT_MAX_A) ? LOCK_TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RD, S_WAIT_RD, S_WR, S_WAIT_WR, S_LOCK
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W:0]   ptr_reg, ptr_next;
  logic [IDX_W:0]   num_reg, num_next;
  logic             err_reg, err_next;
  logic             done_reg, done_next;
  logic             mmcm_rst_reg, mmcm_rst_next;
  logic             den_reg, den_next;
  logic             dwe_reg, dwe_next;
  logic [6:0]       daddr_reg, daddr_next;
  logic [15:0]      di_reg, di_next;
  logic             timeout;

  // Entry table: {addr[38:32], keep-mask[31:16], data[15:0]}; never reset.
  logic [38:0]      tbl_mem [DEPTH];
  logic [IDX_W:0]   ptr_inc;
  logic [IDX_W-1:0] rd_idx;
  logic [38:0]      rd_ent;
  logic [6:0]       rd_addr;
  logic [15:0]      rd_mask;
  logic [15:0]      rd_data;

  assign busy     = (state_reg != S_IDLE);
  assign done     = done_reg;
  assign err      = err_reg;
  assign mmcm_rst = mmcm_rst_reg;
  assign den      = den_reg;
  assign dwe      = dwe_reg;
  assign daddr    = daddr_reg;
  assign di       = di_reg;

  // Look ahead one entry while finishing a write so the next read address is ready.
  assign ptr_inc = ptr_reg + 1'b1;
  assign rd_idx  = (state_reg == S_WAIT_WR) ? ptr_inc[IDX_W-1:0] : ptr_reg[IDX_W-1:0];
  assign rd_ent  = tbl_mem[rd_idx];
  assign rd_addr = rd_ent[38:32];
  assign rd_mask = rd_ent[31:16];
  assign rd_data = rd_ent[15:0];

  // Table writes are accepted only while idle (including the START cycle).
  always_ff @(posedge dclk) begin
    if (tbl_we && !busy) begin
      tbl_mem[tbl_idx] <= tbl_wdata;
    end
  end

  // State and registered outputs.
  always_ff @(posedge dclk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      ptr_reg      <= '0;
      num_reg      <= '0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
      mmcm_rst_reg <= 1'b0;
      den_reg      <= 1'b0;
      dwe_reg      <= 1'b0;
      daddr_reg    <= '0;
      di_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ptr_reg      <= ptr_next;
      num_reg      <= num_next;
      err_reg      <= err_next;
      done_reg     <= done_next;
      mmcm_rst_reg <= mmcm_rst_next;
      den_reg      <= den_next;
      dwe_reg      <= dwe_next;
      daddr_reg    <= daddr_next;
      di_reg       <= di_next;
    end
  end

  // Next-state and output decode; DEN/DWE follow the state being entered.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + CNT_W'(1);
    ptr_next      = ptr_reg;
    num_next      = num_reg;
    err_next      = err_reg;
    done_next     = 1'b0;
    mmcm_rst_next = mmcm_rst_reg;
    daddr_next    = daddr_reg;
    di_next       = di_reg;
    timeout       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_HOLD;
          num_next      = num_ent;
          err_next      = 1'b0;
          ptr_next      = '0;
          cnt_next      = '0;
          mmcm_rst_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next = '0;
          if (num_reg != '0) begin
            state_next = S_RD;
            daddr_next = rd_addr;
          end else begin
            state_next    = S_LOCK;
            mmcm_rst_next = 1'b0;
          end
        end
      end
      S_RD: begin
        state_next = S_WAIT_RD;
        cnt_next   = '0;
      end
      S_WAIT_RD: begin
        if (drdy) begin
          state_next = S_WR;
          daddr_next = rd_addr;
          di_next    = (drp_do & rd_mask) | (rd_data & ~rd_mask);
        end else if (cnt_reg == DRDY_LAST) begin
          timeout = 1'b1;
        end
      end
      S_WR: begin
        state_next = S_WAIT_WR;
        cnt_next   = '0;
      end
      S_WAIT_WR: begin
        if (drdy) begin
          ptr_next = ptr_inc;
          cnt_next = '0;
          if (ptr_inc == num_reg) begin
            state_next    = S_LOCK;
            mmcm_rst_next = 1'b0;
          end else begin
            state_next = S_RD;
            daddr_next = rd_addr;
          end
        end else if (cnt_reg == DRDY_LAST) begin
          timeout = 1'b1;
        end
      end
      S_LOCK: begin
        if (locked) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else if (cnt_reg == LOCK_LAST) begin
          timeout = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (timeout) begin
      state_next    = S_IDLE;
      err_next      = 1'b1;
      mmcm_rst_next = 1'b0;
    end

    den_next = (state_next == S_RD) || (state_next == S_WR);
    dwe_next = (state_next == S_WR);
  end

endmodule

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
// Bench for mmcm_drp_reconfig_ctrl: each scenario is turned into a per-cycle
// schedule of stimulus (DRDY/DO/LOCKED/noise) and expected outputs computed from
// the access sequence, then replayed while every cycle is compared.
module tb_mmcm_drp_reconfig_ctrl;

  localparam int H    = 4;
  localparam int DT   = 64;
  localparam int LT   = 200;
  localparam int MAXC = 1024;

  logic        dclk = 1'b0;
  logic        rst, tbl_we, start, drdy, locked;
  logic        busy, done, err, mmcm_rst, den, dwe;
  logic [4:0]  tbl_idx;
  logic [38:0] tbl_wdata;
  logic [5:0]  num_ent;
  logic [6:0]  daddr;
  logic [15:0] di, drp_do;

  always #5 dclk = ~dclk;

  mmcm_drp_reconfig_ctrl #(
    .DEPTH(32), .IDX_W(5), .RST_HOLD_CYC(H), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
  ) dut (
    .dclk(dclk), .rst(rst), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_wdata(tbl_wdata),
    .num_ent(num_ent), .start(start), .busy(busy), .done(done), .err(err),
    .mmcm_rst(mmcm_rst), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
    .drp_do(drp_do), .drdy(drdy), .locked(locked)
  );

  // Reference state: MMCM register file, table copy, sticky/held outputs
  logic [15:0] mmcm_reg [128];
  logic [38:0] tbl_model [32];
  logic        err_prev;
  logic [6:0]  last_addr, m_addr;
  logic [15:0] last_di, m_di;

  // Per-cycle schedule
  logic        drv_start [MAXC];
  logic        drv_drdy  [MAXC];
  logic        drv_locked[MAXC];
  logic        drv_we    [MAXC];
  logic        drv_rst   [MAXC];
  logic [15:0] drv_do    [MAXC];
  logic [4:0]  drv_idx   [MAXC];
  logic [38:0] drv_wdata [MAXC];
  logic [28:0] exp_v     [MAXC];
  int          len;
  logic [5:0]  cur_num;

  int n_checks = 0;
  int n_errs   = 0;

  // Observations from the last scenario
  int          den_cnt, mrst_cnt, done_cyc;
  logic [6:0]  addr_q[$];
  logic        dwe_q[$];
  logic [15:0] wr_di;
  logic [6:0]  wr_addr;
  logic        err_c0, err_c1;

  logic [6:0]  t2_addr [6];

  task automatic lit(input string name, input int act, input int exp_val);
    n_checks++;
    if (act !== exp_val) begin
      n_errs++;
      $display("FAIL %s: got %0d required %0d", name, act, exp_val);
    end
  endtask

  task automatic put(input int c, input logic b, input logic d, input logic e,
                     input logic mr, input logic dn, input logic dw);
    exp_v[c] = {b, d, e, mr, dn, dw, m_addr, m_di};
  endtask

  task automatic finish_scn(input logic e);
    err_prev  = e;
    last_addr = m_addr;
    last_di   = m_di;
  endtask

  // lock_d < 0: LOCKED never comes. fail_acc: access whose DRDY is withheld.
  // abort_acc: access during whose wait RST is pulsed.
  task automatic build(input int num, input int lock_d, input int fail_acc,
                       input int abort_acc, input int max_lat);
    int c, lat;
    logic [38:0] ent;
    logic [6:0]  a;
    logic [15:0] cur, nv;
    nv = '0;
    for (int i = 0; i < MAXC; i++) begin
      drv_start[i] = 1'b0; drv_drdy[i] = 1'b0; drv_we[i] = 1'b0; drv_rst[i] = 1'b0;
      drv_do[i] = 16'($urandom); drv_locked[i] = 1'($urandom);
      drv_idx[i] = '0; drv_wdata[i] = '0; exp_v[i] = '0;
    end
    cur_num = 6'(num);
    m_addr  = last_addr;
    m_di    = last_di;
    put(0, 0, 0, err_prev, 0, 0, 0);
    drv_start[0] = 1'b1;
    for (int k = 1; k <= H; k++) put(k, 1, 0, 0, 1, 0, 0);
    c = H + 1;
    for (int e = 0; e < num; e++) begin
      ent = tbl_model[e];
      a   = ent[38:32];
      for (int w = 0; w < 2; w++) begin
        m_addr = a;
        if (w == 1) begin
          m_di        = nv;
          mmcm_reg[a] = nv;
        end
        put(c, 1, 0, 0, 1, 1, (w == 1));
        drv_drdy[c] = ($urandom_range(0, 3) == 0);
        if (2 * e + w == fail_acc) begin
          for (int k = 1; k <= DT; k++) put(c + k, 1, 0, 0, 1, 0, 0);
          put(c + DT + 1, 0, 0, 1, 0, 0, 0);
          len = c + DT + 2;
          finish_scn(1'b1);
          return;
        end
        if (2 * e + w == abort_acc) begin
          put(c + 1, 1, 0, 0, 1, 0, 0);
          drv_rst[c + 1] = 1'b1;
          m_addr = '0;
          m_di   = '0;
          put(c + 2, 0, 0, 0, 0, 0, 0);
          len = c + 3;
          finish_scn(1'b0);
          return;
        end
        lat = $urandom_range(1, max_lat);
        for (int k = 1; k <= lat; k++) put(c + k, 1, 0, 0, 1, 0, 0);
        drv_drdy[c + lat] = 1'b1;
        if (w == 0) begin
          cur = mmcm_reg[a];
          drv_do[c + lat] = cur;
          nv = (cur & ent[31:16]) | (ent[15:0] & ~ent[31:16]);
        end
        c = c + lat + 1;
      end
    end
    if (lock_d < 0) begin
      for (int k = 0; k < LT; k++) begin
        put(c + k, 1, 0, 0, 0, 0, 0);
        drv_locked[c + k] = 1'b0;
      end
      put(c + LT, 0, 0, 1, 0, 0, 0);
      len = c + LT + 1;
      finish_scn(1'b1);
    end else begin
      for (int k = 0; k < lock_d; k++) begin
        put(c + k, 1, 0, 0, 0, 0, 0);
        drv_locked[c + k] = 1'b0;
      end
      put(c + lock_d, 1, 0, 0, 0, 0, 0);
      drv_locked[c + lock_d] = 1'b1;
      put(c + lock_d + 1, 0, 1, 0, 0, 0, 0);
      put(c + lock_d + 2, 0, 0, 0, 0, 0, 0);
      len = c + lock_d + 3;
      finish_scn(1'b0);
    end
  endtask

  // Spurious START and table writes while busy; both must be ignored.
  task automatic add_noise();
    for (int c = 1; c < len; c++) begin
      if (exp_v[c][28] && $urandom_range(0, 5) == 0) begin
        drv_start[c] = 1'b1;
        drv_we[c]    = 1'b1;
        drv_idx[c]   = 5'($urandom_range(0, 7));
        drv_wdata[c] = 39'({$urandom, $urandom});
      end
    end
  endtask

  // Replay the schedule; called at posedge+1.
  task automatic run_scn(input int id);
    logic [28:0] act;
    logic        prev_den;
    prev_den = 1'b0; den_cnt = 0; mrst_cnt = 0; done_cyc = -1;
    addr_q.delete(); dwe_q.delete(); wr_di = '0; wr_addr = '0;
    err_c0 = 1'b0; err_c1 = 1'b0;
    for (int c = 0; c < len; c++) begin
      start = drv_start[c]; drdy = drv_drdy[c]; drp_do = drv_do[c];
      locked = drv_locked[c]; tbl_we = drv_we[c]; tbl_idx = drv_idx[c];
      tbl_wdata = drv_wdata[c]; rst = drv_rst[c]; num_ent = cur_num;
      @(negedge dclk);
      act = {busy, done, err, mmcm_rst, den, dwe & den, daddr, di};
      n_checks++;
      if (act !== exp_v[c]) begin
        n_errs++;
        $display("FAIL scn%0d cyc%0d outputs: got busy=%b done=%b err=%b mrst=%b den=%b dwe=%b daddr=%h di=%h required busy=%b done=%b err=%b mrst=%b den=%b dwe=%b daddr=%h di=%h",
                 id, c, act[28], act[27], act[26], act[25], act[24], act[23], act[22:16], act[15:0],
                 exp_v[c][28], exp_v[c][27], exp_v[c][26], exp_v[c][25], exp_v[c][24], exp_v[c][23],
                 exp_v[c][22:16], exp_v[c][15:0]);
      end
      if (den) begin
        n_checks++;
        if (prev_den) begin
          n_errs++;
          $display("FAIL scn%0d cyc%0d den_spacing: got den=1 after den=1 required den=0 in previous cycle", id, c);
        end
        den_cnt++;
        addr_q.push_back(daddr);
        dwe_q.push_back(dwe);
        if (dwe) begin
          wr_di   = di;
          wr_addr = daddr;
        end
      end
      prev_den = den;
      if (mmcm_rst) mrst_cnt++;
      if (done) done_cyc = c;
      if (c == 0) err_c0 = err;
      if (c == 1) err_c1 = err;
      @(posedge dclk);
      #1;
    end
    start = 1'b0; drdy = 1'b0; tbl_we = 1'b0; rst = 1'b0;
    $display("scn %0d: num=%0d cycles=%0d den=%0d done_cyc=%0d err=%b", id, cur_num, len, den_cnt, done_cyc, err);
  endtask

  task automatic load_tbl(input int i, input logic [38:0] v);
    tbl_we = 1'b1; tbl_idx = 5'(i); tbl_wdata = v; tbl_model[i] = v;
    @(posedge dclk);
    #1;
    tbl_we = 1'b0;
  endtask

  initial begin
    int n, mode, fail, abrt, lockd;
    rst = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_wdata = '0; num_ent = '0;
    start = 1'b0; drp_do = '0; drdy = 1'b0; locked = 1'b0;
    for (int i = 0; i < 128; i++) mmcm_reg[i] = 16'($urandom);
    for (int i = 0; i < 32; i++) tbl_model[i] = '0;
    err_prev = 1'b0; last_addr = '0; last_di = '0; m_addr = '0; m_di = '0;
    t2_addr[0] = 7'h08; t2_addr[1] = 7'h08; t2_addr[2] = 7'h09;
    t2_addr[3] = 7'h09; t2_addr[4] = 7'h14; t2_addr[5] = 7'h14;
    repeat (3) @(posedge dclk);
    #1;
    @(negedge dclk);
    lit("reset_busy", int'(busy), 0);
    lit("reset_done", int'(done), 0);
    lit("reset_err", int'(err), 0);
    lit("reset_mmcm_rst", int'(mmcm_rst), 0);
    lit("reset_den", int'(den), 0);
    lit("reset_dwe", int'(dwe), 0);
    lit("reset_daddr", int'(daddr), 0);
    lit("reset_di", int'(di), 0);
    @(posedge dclk);
    #1;
    rst = 1'b0;
    @(posedge dclk);
    #1;

    // 1: single entry loaded in the START cycle
    mmcm_reg[8]  = 16'h1FFF;
    tbl_model[0] = {7'h08, 16'h1000, 16'h0041};
    build(1, 0, -1, -1, 1);
    drv_we[0] = 1'b1; drv_idx[0] = '0; drv_wdata[0] = tbl_model[0];
    run_scn(1);
    lit("t1_wr_addr", int'(wr_addr), 8);
    lit("t1_wr_di", int'(wr_di), 'h1041);
    lit("t1_done_cyc", done_cyc, 10);
    lit("t1_mrst_cycles", mrst_cnt, 8);
    lit("t1_den_cnt", den_cnt, 2);

    // 2: three entries, access order and write flags
    load_tbl(0, {7'h08, 16'($urandom), 16'($urandom)});
    load_tbl(1, {7'h09, 16'($urandom), 16'($urandom)});
    load_tbl(2, {7'h14, 16'($urandom), 16'($urandom)});
    build(3, 2, -1, -1, 3);
    add_noise();
    run_scn(2);
    lit("t2_den_cnt", den_cnt, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < addr_q.size()) begin
        lit($sformatf("t2_addr%0d", i), int'(addr_q[i]), int'(t2_addr[i]));
        lit($sformatf("t2_dwe%0d", i), int'(dwe_q[i]), i % 2);
      end
    end

    // 3: no entries, reset pulse only
    build(0, 3, -1, -1, 1);
    run_scn(3);
    lit("t3_mrst_cycles", mrst_cnt, H);
    lit("t3_den_cnt", den_cnt, 0);
    lit("t3_done_cyc", done_cyc, 9);

    // 4: DRDY withheld on the second read, then a START clears ERR
    load_tbl(0, {7'h21, 16'($urandom), 16'($urandom)});
    load_tbl(1, {7'h22, 16'($urandom), 16'($urandom)});
    build(2, 0, 2, -1, 2);
    run_scn(4);
    lit("t4_no_done", done_cyc, -1);
    build(1, 1, -1, -1, 2);
    run_scn(5);
    lit("t4_err_before_start", int'(err_c0), 1);
    lit("t4_err_cleared", int'(err_c1), 0);

    // 5: LOCKED never arrives, with START/TBL_WE noise while busy
    build(1, -1, -1, -1, 2);
    add_noise();
    run_scn(6);
    lit("t5_no_done", done_cyc, -1);
    build(1, 0, -1, -1, 1);
    run_scn(7);
    lit("t5_rerun_done_cyc", done_cyc, 10);

    // 6: RST during the first write wait, then a clean rerun
    load_tbl(0, {7'h30, 16'($urandom), 16'($urandom)});
    load_tbl(1, {7'h31, 16'($urandom), 16'($urandom)});
    build(2, 0, -1, 1, 1);
    run_scn(8);
    lit("t6_no_done", done_cyc, -1);
    build(2, 0, -1, -1, 1);
    run_scn(9);
    lit("t6_rerun_done_cyc", done_cyc, 14);

    // Randomized scenarios
    for (int s = 0; s < 24; s++) begin
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) load_tbl(i, 39'({$urandom, $urandom}));
      mode  = $urandom_range(0, 9);
      fail  = (mode == 0 && n > 0) ? $urandom_range(0, 2 * n - 1) : -1;
      abrt  = (mode == 1 && n > 0) ? 2 * $urandom_range(0, n - 1) + 1 : -1;
      lockd = (mode == 2) ? -1 : $urandom_range(0, 6);
      build(n, lockd, fail, abrt, 4);
      add_noise();
      run_scn(10 + s);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
